// File: rtl/gfx_wbm_rw_master.sv
// Wishbone B4 classic master: runs one CYC/STB transfer per arbiter request and
// returns a one-cycle ack with read data; err/timeout aborts set a sticky error flag.
module gfx_wbm_rw_master #(
  parameter int MDW     = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             read_request_i,
  input  logic             write_request_i,
  input  logic [31:0]      addr_i,
  input  logic             we_i,
  input  logic [MDW/8-1:0] sel_i,
  input  logic [MDW-1:0]   dat_i,
  output logic [MDW-1:0]   dat_o,
  output logic             ack_o,
  output logic             err_o,
  input  logic             err_clr_i,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [31:0]      wb_adr_o,
  output logic [MDW/8-1:0] wb_sel_o,
  output logic [MDW-1:0]   wb_dat_o,
  input  logic [MDW-1:0]   wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  localparam int              SW       = MDW / 8;
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [31:0]     ADR_MASK = ~32'(SW - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          start, done_ok, done_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    start      = 1'b0;
    done_ok    = 1'b0;
    done_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (read_request_i || write_request_i) begin
          start      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (wb_ack_i) begin
          done_ok    = 1'b1;
          state_next = RECOVER;
        end else if (wb_err_i || cnt == CNT_LAST) begin
          done_err   = 1'b1;
          state_next = RECOVER;
        end
      end
      // The arbiter still shows the old request here, so it is deliberately ignored.
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // Wide data registers are reset too: outputs must read as zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      dat_o    <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
      cnt      <= '0;
    end else begin
      ack_o <= done_ok | done_err;

      if (start) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= write_request_i | (we_i & ~read_request_i);
        wb_adr_o <= addr_i & ADR_MASK;
        wb_sel_o <= sel_i;
        wb_dat_o <= dat_i;
      end else if (done_ok || done_err) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
      end

      if (done_ok && !wb_we_o) dat_o <= wb_dat_i;
      else if (done_err)       dat_o <= '1;

      // A new error outranks a simultaneous clear.
      if (done_err)       err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;

      if (state == ACCESS) cnt <= cnt + CW'(1);
      else                 cnt <= '0;
    end
  end

endmodule

// File: tb/tb_gfx_wbm_rw_master.sv
// Bench for gfx_wbm_rw_master: transaction-level model checked every cycle,
// plus directed read/write/back-to-back/timeout/err/reset scenarios with literal expectations.
module tb_gfx_wbm_rw_master;

  localparam int MDW     = 256;
  localparam int SW      = MDW / 8;
  localparam int TIMEOUT = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           read_req, write_req, we, err_clr;
  logic [31:0]    addr;
  logic [SW-1:0]  sel;
  logic [MDW-1:0] wdat, dat_o, read_data;
  logic           ack_o, err_o;
  logic           wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]    wb_adr_o;
  logic [SW-1:0]  wb_sel_o;
  logic [MDW-1:0] wb_dat_o;
  logic           wb_ack_i = 1'b0, wb_err_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  gfx_wbm_rw_master #(.MDW(MDW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .read_request_i(read_req), .write_request_i(write_req),
    .addr_i(addr), .we_i(we), .sel_i(sel), .dat_i(wdat),
    .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .err_clr_i(err_clr),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(read_data), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [MDW-1:0] act, input logic [MDW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: acks (or errs) when STB has been up for a programmed number of cycles.
  int ack_delay = -1;   // -1: never ack; else ack in STB cycle ack_delay+1
  int err_at    = 0;    // 0: never err; else err in STB cycle err_at
  int stb_cyc   = 0;
  always @(posedge clk) begin
    #2;
    if (wb_cyc_o) stb_cyc++;
    else          stb_cyc = 0;
    wb_ack_i = (ack_delay >= 0) && (stb_cyc == ack_delay + 1);
    wb_err_i = (err_at > 0) && (stb_cyc == err_at);
  end

  // Behavioural model: one transfer in flight, then one ack cycle, then idle.
  logic           m_cyc, m_ack, m_err, m_we;
  logic [31:0]    m_adr;
  logic [SW-1:0]  m_sel;
  logic [MDW-1:0] m_wdat, m_dat;
  int             m_wait;
  bit             m_set_err;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_ack = 0; m_err = 0; m_we = 0;
      m_adr = '0; m_sel = '0; m_wdat = '0; m_dat = '0; m_wait = 0;
    end else begin
      m_set_err = 0;
      if (m_ack) begin
        m_ack = 0;
      end else if (m_cyc) begin
        m_wait++;
        if (wb_ack_i) begin
          m_cyc = 0; m_ack = 1;
          if (!m_we) m_dat = read_data;
        end else if (wb_err_i || m_wait == TIMEOUT) begin
          m_cyc = 0; m_ack = 1; m_dat = '1; m_set_err = 1;
        end
      end else if (read_req || write_req) begin
        m_cyc  = 1;
        m_wait = 0;
        m_we   = write_req ? 1'b1 : (we && !read_req);
        m_adr  = {addr[31:$clog2(SW)], {$clog2(SW){1'b0}}};
        m_sel  = sel;
        m_wdat = wdat;
      end
      if (m_set_err)    m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  // Compare process plus bus-cycle statistics.
  int   cyc_hi = 0, cyc_rises = 0;
  logic cyc_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc", wb_cyc_o, m_cyc);
      check("stb", wb_stb_o, m_cyc);
      check("ack", ack_o, m_ack);
      check("err", err_o, m_err);
      check("dat_o", dat_o, m_dat);
      if (m_cyc) begin
        check("wb_we", wb_we_o, m_we);
        check("wb_adr", wb_adr_o, m_adr);
        check("wb_sel", wb_sel_o, m_sel);
        check("wb_dat", wb_dat_o, m_wdat);
      end
      if (wb_cyc_o) cyc_hi++;
      if (wb_cyc_o && !cyc_prev) cyc_rises++;
    end
    cyc_prev = wb_cyc_o;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present a request and return in the cycle where ack_o is high.
  task automatic do_xfer(input logic rd, input logic wr, input logic w, input logic [31:0] a,
                         input logic [SW-1:0] s, input logic [MDW-1:0] d, output int lat);
    read_req = rd; write_req = wr; we = w; addr = a; sel = s; wdat = d;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!ack_o && lat < 40);
    check("xfer_done", ack_o, 1'b1);
  endtask

  // Hold the request through the ack cycle, then withdraw it.
  task automatic finish_xfer();
    step();
    read_req = 0; write_req = 0;
  endtask

  initial begin
    int lat, c0, h0;
    rst_n = 0; read_req = 0; write_req = 0; we = 0; err_clr = 0;
    addr = '0; sel = '0; wdat = '0; read_data = {32{8'hA5}};
    #1;
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_ack", ack_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_dat_o", dat_o, '0);
    check("rst_adr", wb_adr_o, '0);
    step(); rst_n = 1;
    step();

    // 1: read, slave acks in the 4th STB cycle
    ack_delay = 3; c0 = cyc_rises;
    do_xfer(1, 0, 0, 32'h1000_0025, '1, '0, lat);
    check("rd_lat", lat, 5);
    check("rd_adr", wb_adr_o, 32'h1000_0020);
    check("rd_we", wb_we_o, 1'b0);
    check("rd_dat", dat_o, {32{8'hA5}});
    check("rd_cyc_in_recover", wb_cyc_o, 1'b0);
    finish_xfer();
    check("rd_ack_pulse", ack_o, 1'b0);
    step();
    check("rd_one_cycle", cyc_rises - c0, 1);

    // 2: write acked on the first STB cycle
    ack_delay = 0;
    do_xfer(0, 1, 1, 32'h2000_0040, '1, {8{32'h1234_5678}}, lat);
    check("wr_lat", lat, 2);
    check("wr_we", wb_we_o, 1'b1);
    check("wr_wdat", wb_dat_o, {8{32'h1234_5678}});
    check("wr_sel", wb_sel_o, {SW{1'b1}});
    check("wr_dat_o_kept", dat_o, {32{8'hA5}});
    finish_xfer();
    step();

    // 3: back-to-back; read with we_i=1 stays a read, then both requests -> write
    ack_delay = 1; read_data = {8{32'hDEAD_BEEF}}; c0 = cyc_rises;
    do_xfer(1, 0, 1, 32'h3000_0000, 32'h0000_FFFF, '0, lat);
    check("b2b_rd_lat", lat, 3);
    check("b2b_rd_dat", dat_o, {8{32'hDEAD_BEEF}});
    step();
    do_xfer(1, 1, 0, 32'h3000_0100, 32'hF0F0_F0F0, {8{32'hCAFE_0001}}, lat);
    check("b2b_wr_lat", lat, 3);
    check("b2b_write_wins", wb_we_o, 1'b1);
    check("b2b_dat_kept", dat_o, {8{32'hDEAD_BEEF}});
    finish_xfer();
    repeat (3) step();
    check("b2b_two_cycles", cyc_rises - c0, 2);

    // 4: timeout, slave never responds
    ack_delay = -1; h0 = cyc_hi;
    do_xfer(1, 0, 0, 32'h4000_0000, '1, '0, lat);
    check("to_lat", lat, 9);
    check("to_dat", dat_o, {MDW{1'b1}});
    check("to_err", err_o, 1'b1);
    finish_xfer();
    check("to_cyc_len", cyc_hi - h0, 8);
    repeat (3) step();
    check("to_err_sticky", err_o, 1'b1);
    err_clr = 1; step(); err_clr = 0;
    check("to_err_clr", err_o, 1'b0);

    // 5: err_i in the 2nd ACCESS cycle, then set-vs-clear collision
    ack_delay = 0; read_data = {64{4'h3}};
    do_xfer(1, 0, 0, 32'h5000_0000, '1, '0, lat);
    finish_xfer();
    check("pre_err_dat", dat_o, {64{4'h3}});
    ack_delay = -1; err_at = 2;
    do_xfer(1, 0, 0, 32'h5000_0080, '1, '0, lat);
    check("err_lat", lat, 3);
    check("err_dat", dat_o, {MDW{1'b1}});
    check("err_set", err_o, 1'b1);
    finish_xfer();
    err_clr = 1; step();
    check("err_clr", err_o, 1'b0);
    do_xfer(0, 1, 1, 32'h5000_00C0, '1, '0, lat);
    err_clr = 0;
    check("set_wins", err_o, 1'b1);
    finish_xfer();
    step();
    check("set_wins_kept", err_o, 1'b1);

    // 6: asynchronous reset in the middle of ACCESS
    err_at = 0; ack_delay = -1;
    read_req = 1; addr = 32'h6000_0000; sel = '1;
    step(); step();
    check("pre_rst_cyc", wb_cyc_o, 1'b1);
    #1 rst_n = 0;
    #1;
    check("arst_cyc", wb_cyc_o, 1'b0);
    check("arst_stb", wb_stb_o, 1'b0);
    check("arst_ack", ack_o, 1'b0);
    check("arst_err", err_o, 1'b0);
    read_req = 0;
    step(); step();
    rst_n = 1;
    step();
    ack_delay = 2; read_data = {16{16'h5A3C}}; c0 = cyc_rises;
    do_xfer(1, 0, 0, 32'h6000_001F, '1, '0, lat);
    check("post_rst_lat", lat, 4);
    check("post_rst_adr", wb_adr_o, 32'h6000_0000);
    check("post_rst_dat", dat_o, {16{16'h5A3C}});
    finish_xfer();
    repeat (2) step();
    check("post_rst_one_cycle", cyc_rises - c0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
